mips_hazard_fwd_unit: RTL
=========================

Name: mips_hazard_fwd_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding logic in the 5-stage MIPS32 pipeline.
- Keeps its own shadow pipeline of destination tags (EX/MEM/WB), so the datapath no longer routes per-stage rd/rt/opcode into it.
- Generates registered per-operand forward selects aligned with the EX stage, a load-use stall, and a multi-cycle MULT/DIV busy interlock.
- Sits beside the ID/EX pipeline register; its stall drives the PC/IF-ID hold and the ID/EX bubble.

Parameters:
- REG_ADDR_W, 5, register-address width.
- NUM_SRC, 2, source operands per instruction (operand 0 = rs, 1 = rt).
- MD_LATENCY, 4, cycles MULT/DIV occupies the HI/LO unit (≥1).
- MD_CNT_W, 3, counter width; must hold MD_LATENCY.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_ADDR_W  packed source register numbers; operand i at [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  operand i is actually read (e.g. ADDI does not read rt).
- id_dst  in  REG_ADDR_W  destination after rd/rt mux.
- id_wen  in  1  instruction writes the register file.
- id_is_load  in  1  LW-class instruction.
- id_is_md  in  1  MULT/MULTU/DIV/DIVU.
- id_hilo_rd  in  1  MFHI/MFLO.
- ex_flush  in  1  branch/jump resolved taken; kill the instruction leaving ID.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- stall_cause  out  2  00 none, 01 load-use, 10 HI/LO busy.
- fwd_sel  out  2*NUM_SRC  per-operand select for the EX instruction: 00 regfile, 01 MEM/WB ALU result, 10 EX/MEM ALU result, 11 MEM/WB load data.
- md_busy  out  1  HI/LO unit occupied.

Behaviour:
- The core asserts the async reset asynchronously and releases it synchronously.
- Reset:
  - All tracker entries invalid; fwd_sel = 0; md counter = 0.
  - Therefore stall = 0, stall_cause = 00, md_busy = 0.
- Tracker:
  - Three entries T_EX, T_MEM, T_WB, each {valid, dst, wen, is_load}.
  - Every clock: T_WB <= T_MEM and T_MEM <= T_EX.
  - T_EX <= ID entry when id_valid && !stall && !ex_flush; otherwise T_EX becomes a bubble (valid = 0).
  - An entry counts as a writer only when valid && wen && dst != 0.
- Forward select (registered, updated every clock, per operand i):
  - Condition: ID transfers (id_valid && !stall && !ex_flush) and id_src_used[i].
  - Then fwd_sel[i] is the first match in this order:
    - T_EX writer with dst == src[i] → 10.
    - Else T_MEM writer with dst == src[i] → 11 if T_MEM.is_load, else 01.
    - Else 00.
  - Any other cycle (no transfer, or operand unused) → 00.
  - A T_EX load match never reaches this path because load-use stalls first.
  - Source register 0 always yields 00.
- Load-use stall (combinational):
  - Asserted when id_valid && !ex_flush && some used src[i] equals the T_EX dst, and T_EX is a writer with is_load.
  - Lasts exactly 1 cycle; the next cycle the load sits in T_MEM and selects 11.
- HI/LO interlock:
  - The md counter loads MD_LATENCY when an id_is_md instruction transfers.
  - Otherwise it decrements toward 0 and saturates at 0.
  - md_busy = (counter != 0).
  - Stall when id_valid && !ex_flush && (id_is_md || id_hilo_rd) && md_busy.
- stall_cause priority: load-use (01) over HI/LO (10). stall = (stall_cause != 00).
- ex_flush:
  - Forces stall low and bubbles T_EX.
  - Does not cancel an already-running md counter.
- Simultaneous stall and flush → flush wins.
- Reset mid-operation discards all in-flight tags and the counter.

Decomposition:
- Shared package mips_pkg holds:
  - forward-select constants FWD_RF/FWD_WB_ALU/FWD_EXMEM_ALU/FWD_WB_LOAD;
  - stall_cause constants;
  - the tracker-entry struct typedef;
  - opcode constants (LW 6'b100011, ADDI 6'b001000).
- One natural sub-module: mips_hilo_busy_ctr, the parametrised md counter that produces md_busy.

Test Plan:
- Reset: hold rst_n = 0 mid-stream, release → fwd_sel = 0, stall = 0, md_busy = 0; the first instruction reading $t0 gets 00.
- Back-to-back ALU: ADD $8 ← …, then SUB reading rs = $8 → fwd_sel[1:0] = 10 in SUB's EX cycle. A third instruction reading $8 two slots later → 01.
- Load-use: LW $9, then ADD rt = $9.
  - stall = 1 with stall_cause = 01 for exactly one cycle.
  - After the stall, fwd_sel[3:2] = 11 and no stall.
- Priority: ADD $5 then ADD $5 then OR reading $5 → 10 (youngest wins). An instruction writing $0 followed by a reader of $0 → 00.
- HI/LO: MULT, then MFHI the next cycle with MD_LATENCY = 4 → stall_cause = 10 until the counter reaches 0, then MFHI proceeds with md_busy = 0.
- Flush: assert ex_flush during a load-use stall → stall = 0, T_EX bubble, and the following reader of that register gets no forward from the killed instruction.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 hazard/forwarding unit.
// Holds the forward-select and stall-cause encodings, the tracker-entry
// payload, a helper that classifies a tracker entry as a register writer,
// and the opcode constants used when talking about instruction classes.
package mips_pkg;

   // Tracker tags are stored at this fixed width; register numbers are
   // zero-extended into it, so any REG_ADDR_W up to this value is supported.
   localparam int unsigned TRK_DST_W = 8;

   // Per-operand forward selects
   localparam logic [1:0] FWD_RF        = 2'b00;
   localparam logic [1:0] FWD_WB_ALU    = 2'b01;
   localparam logic [1:0] FWD_EXMEM_ALU = 2'b10;
   localparam logic [1:0] FWD_WB_LOAD   = 2'b11;

   // Stall causes
   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_LOAD_USE = 2'b01;
   localparam logic [1:0] CAUSE_HILO     = 2'b10;

   // Opcodes of the instruction classes this unit reasons about
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // One shadow-pipeline slot
   typedef struct packed {
      logic                 valid;
      logic                 wen;
      logic                 is_load;
      logic [TRK_DST_W-1:0] dst;
   } trk_entry_t;

   // A slot can only produce a forward if it really writes a non-zero register
   function automatic logic trk_is_writer(input trk_entry_t e);
      return e.valid && e.wen && (e.dst != '0);
   endfunction

endpackage

// File: rtl/mips_hilo_busy_ctr.sv
// HI/LO occupancy counter.
// Loads MD_LATENCY when a MULT/DIV enters EX, then counts down to zero and
// saturates there. md_busy is registered alongside the count so it equals
// (count != 0) without a combinational path from the counter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       a MULT/DIV is transferring from ID into EX this cycle
//   md_busy     HI/LO unit occupied
module mips_hilo_busy_ctr
   import mips_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned MD_CNT_W   = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic md_busy
);

   logic [MD_CNT_W-1:0] cnt;
   logic [MD_CNT_W-1:0] cnt_d;

   // Next count: reload on a new MULT/DIV, else decrement toward zero
   always_comb begin
      cnt_d = cnt;
      if (start) begin
         cnt_d = MD_CNT_W'(MD_LATENCY);
      end else if (cnt != '0) begin
         cnt_d = cnt - MD_CNT_W'(1);
      end
   end

   // Count and busy flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         md_busy <= 1'b0;
      end else begin
         cnt     <= cnt_d;
         md_busy <= (cnt_d != '0);
      end
   end

endmodule

// File: rtl/mips_hazard_fwd_unit.sv
// EX-stage forwarding and hazard unit for the 5-stage MIPS32 pipeline.
// Keeps a shadow pipeline of destination tags (EX/MEM/WB) so the datapath
// only presents the instruction in ID. Produces registered forward selects
// aligned with the EX stage, a combinational load-use / HI/LO stall, and the
// HI/LO busy flag.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   id_valid      ID holds a real instruction
//   id_src        packed source register numbers, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_src_used   operand i is actually read
//   id_dst        destination register after rd/rt mux
//   id_wen        instruction writes the register file
//   id_is_load    LW-class instruction
//   id_is_md      MULT/MULTU/DIV/DIVU
//   id_hilo_rd    MFHI/MFLO
//   ex_flush      kill the instruction leaving ID
//   stall         hold PC and IF/ID, bubble ID/EX
//   stall_cause   00 none, 01 load-use, 10 HI/LO busy
//   fwd_sel       2 bits per operand for the EX instruction
//   md_busy       HI/LO unit occupied
module mips_hazard_fwd_unit
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned MD_CNT_W   = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic [REG_ADDR_W-1:0]         id_dst,
   input  logic                          id_wen,
   input  logic                          id_is_load,
   input  logic                          id_is_md,
   input  logic                          id_hilo_rd,
   input  logic                          ex_flush,
   output logic                          stall,
   output logic [1:0]                    stall_cause,
   output logic [2*NUM_SRC-1:0]          fwd_sel,
   output logic                          md_busy
);

   trk_entry_t           t_ex;
   trk_entry_t           t_mem;
   trk_entry_t           t_wb;
   trk_entry_t           id_entry;
   logic [TRK_DST_W-1:0] src_tag [NUM_SRC];
   logic                 lu_hit;
   logic                 load_use;
   logic                 hilo_wait;
   logic                 xfer;
   logic [2*NUM_SRC-1:0] fwd_d;

   // Source register numbers widened to tag width
   always_comb begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         src_tag[i] = TRK_DST_W'(id_src[i*REG_ADDR_W +: REG_ADDR_W]);
      end
   end

   // Stall detection; a flush kills the ID instruction so it never stalls
   always_comb begin
      lu_hit = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (id_src_used[i] && trk_is_writer(t_ex) && t_ex.is_load &&
             (t_ex.dst == src_tag[i])) begin
            lu_hit = 1'b1;
         end
      end
      load_use  = id_valid && !ex_flush && lu_hit;
      hilo_wait = id_valid && !ex_flush && (id_is_md || id_hilo_rd) && md_busy;

      stall_cause = CAUSE_NONE;
      if (load_use) begin
         stall_cause = CAUSE_LOAD_USE;
      end else if (hilo_wait) begin
         stall_cause = CAUSE_HILO;
      end
      stall = (stall_cause != CAUSE_NONE);
      xfer  = id_valid && !stall && !ex_flush;
   end

   // Forward selects for the instruction about to enter EX; youngest producer wins
   always_comb begin
      fwd_d = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (xfer && id_src_used[i]) begin
            if (trk_is_writer(t_ex) && (t_ex.dst == src_tag[i])) begin
               fwd_d[2*i +: 2] = FWD_EXMEM_ALU;
            end else if (trk_is_writer(t_mem) && (t_mem.dst == src_tag[i])) begin
               fwd_d[2*i +: 2] = t_mem.is_load ? FWD_WB_LOAD : FWD_WB_ALU;
            end
         end
      end
   end

   // Tag entering EX; anything that does not transfer becomes a bubble
   always_comb begin
      id_entry = '0;
      if (xfer) begin
         id_entry.valid   = 1'b1;
         id_entry.wen     = id_wen;
         id_entry.is_load = id_is_load;
         id_entry.dst     = TRK_DST_W'(id_dst);
      end
   end

   // Shadow pipeline and registered forward selects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_ex    <= '0;
         t_mem   <= '0;
         t_wb    <= '0;
         fwd_sel <= '0;
      end else begin
         t_wb    <= t_mem;
         t_mem   <= t_ex;
         t_ex    <= id_entry;
         fwd_sel <= fwd_d;
      end
   end

   // The WB slot is kept so the tracker mirrors the full back end; the
   // register file's own write-before-read covers WB, so nothing reads it yet.
   logic unused_wb;
   assign unused_wb = ^t_wb;

   // HI/LO occupancy
   mips_hilo_busy_ctr #(
      .MD_LATENCY (MD_LATENCY),
      .MD_CNT_W   (MD_CNT_W)
   ) u_hilo_busy (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (xfer && id_is_md),
      .md_busy (md_busy)
   );

endmodule
